mac8x8_accum: RTL and testbench

Pipelined signed multiply-accumulate stage built around the existing combinational `mplier8x8`. It accepts a stream of 8-bit signed operand pairs over a valid/ready handshake, registers them into the multiplier, and sums the 16-bit signed products of one frame into a wide accumulator. When the beat marked `last` is accumulated, the total is presented downstream over a second valid/ready handshake. The block sits directly downstream of operand sources and consumes every product `mplier8x8` produces.

---
 rtl/mac8x8_pkg.sv | 22 ++
 rtl/mplier8x8.sv | 8 +
 rtl/mac8x8_accum.sv | 146 ++++++++++++++
 tb/tb_mac8x8_accum.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac8x8_pkg.sv
// Shared constants, frame FSM encoding and saturation limits for mac8x8_accum.
// The limits are only used when the build defines MAC_SAT_EN.
package mac8x8_pkg;

    localparam int ACC_W_DEF = 24;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } frame_state_t;

    // 33 bits covers every legal accumulator width plus one guard bit.
    function automatic logic signed [32:0] sat_max(input int w);
        return (33'sd1 <<< (w - 1)) - 33'sd1;
    endfunction

    function automatic logic signed [32:0] sat_min(input int w);
        return -(33'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mplier8x8.sv
// Combinational 8x8 two's-complement multiplier with a full 16-bit product.
module mplier8x8 (
    input  logic signed [7:0]  i_a,
    input  logic signed [7:0]  i_b,
    output logic signed [15:0] o_p
);
    assign o_p = 16'(i_a) * 16'(i_b);
endmodule

// File: rtl/mac8x8_accum.sv
// Three-stage signed multiply-accumulate with framed results over valid/ready.
// Optional MAC_SAT_EN: saturating accumulation with a sticky per-frame overflow flag.
module mac8x8_accum
    import mac8x8_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [7:0]       a,
    input  logic signed [7:0]       b,
    input  logic                    last,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    overflow
);
    logic                    w_en;
    logic                    w_take;
    logic signed [15:0]      w_prod;
    logic signed [ACC_W-1:0] w_sum;

    logic signed [7:0]       r_s1_a;
    logic signed [7:0]       r_s1_b;
    logic                    r_s1_last;
    logic                    r_s1_valid;
    logic signed [15:0]      r_s2_prod;
    logic                    r_s2_last;
    logic                    r_s2_valid;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out_acc;
    frame_state_t            r_state;
    frame_state_t            w_state_next;

    // A result waiting on a stalled consumer freezes the whole pipeline.
    assign w_en      = !(out_valid && !out_ready);
    assign in_ready  = w_en && !clear && !rst;
    assign w_take    = r_s2_valid && w_en && !clear;
    assign out_valid = (r_state == S_HOLD);
    assign out_acc   = r_out_acc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
        end
        if (w_en) begin
            r_s1_a    <= a;
            r_s1_b    <= b;
            r_s1_last <= last;
            r_s2_prod <= w_prod;
            r_s2_last <= r_s1_last;
        end
    end

    mplier8x8 u_mplier (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_prod)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_EMPTY: if (w_take) w_state_next = r_s2_last ? S_HOLD : S_ACCUM;
            S_ACCUM: begin
                if (clear)                     w_state_next = S_EMPTY;
                else if (w_take && r_s2_last)  w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (w_take) w_state_next = r_s2_last ? S_HOLD : S_ACCUM;
                    else        w_state_next = S_EMPTY;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_next;
    end

`ifdef MAC_SAT_EN
    localparam logic signed [32:0] SAT_MAX = sat_max(ACC_W);
    localparam logic signed [32:0] SAT_MIN = sat_min(ACC_W);

    logic signed [32:0] w_wide;
    logic               w_sat;
    logic               r_flag;
    logic               r_ovf;

    assign w_wide = 33'(r_acc) + 33'(r_s2_prod);

    always_comb begin
        w_sum = w_wide[ACC_W-1:0];
        w_sat = 1'b0;
        if (w_wide > SAT_MAX) begin
            w_sum = SAT_MAX[ACC_W-1:0];
            w_sat = 1'b1;
        end else if (w_wide < SAT_MIN) begin
            w_sum = SAT_MIN[ACC_W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_flag <= 1'b0;
        end else if (w_take) begin
            r_flag <= r_s2_last ? 1'b0 : (r_flag | w_sat);
        end
        if (rst)                      r_ovf <= 1'b0;
        else if (w_take && r_s2_last) r_ovf <= r_flag | w_sat;
    end

    assign overflow = r_ovf;
`else
    assign w_sum    = r_acc + ACC_W'(r_s2_prod);
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_out_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (w_take) begin
            if (r_s2_last) begin
                r_out_acc <= w_sum;
                r_acc     <= '0;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_mac8x8_accum.sv
// Self-checking bench for mac8x8_accum: directed frames, a vector table, and a
// randomized handshake run against a frame-sum reference model.
module tb_mac8x8_accum;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, last, clear, out_ready;
    logic signed [7:0] a, b;
    logic              in_ready, out_valid, overflow;
    logic signed [23:0] out_acc;
    logic              in_ready16, out_valid16, overflow16;
    logic signed [15:0] out_acc16;

    int n_checks = 0;
    int n_fail   = 0;

    mac8x8_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .last(last), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .overflow(overflow)
    );

    mac8x8_accum #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .last(last), .clear(clear), .out_valid(out_valid16),
        .out_ready(out_ready), .out_acc(out_acc16), .overflow(overflow16)
    );

    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t    vecs[7];
    longint  exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int av, input int bv, input bit l);
        a = 8'(av);
        b = 8'(bv);
        last = l;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        longint run;
        int     flen;
        longint sat16_exp;
        longint ovf16_exp;
        logic signed [23:0] wrap24;

        vecs[0] = '{3, 4, 12};
        vecs[1] = '{-128, -128, 16384};
        vecs[2] = '{127, -128, -16256};
        vecs[3] = '{-1, -1, 1};
        vecs[4] = '{0, 77, 0};
        vecs[5] = '{-7, 9, -63};
        vecs[6] = '{127, 127, 16129};

        rst = 1'b1; in_valid = 1'b0; last = 1'b0; clear = 1'b0;
        out_ready = 1'b1; a = '0; b = '0;
        tick(); tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_acc", out_acc, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        // Three-beat frame, result two cycles after the last beat.
        beat(3, 4, 0); beat(-5, 6, 0); beat(127, 127, 1);
        in_valid = 1'b0;
        chk("f1_valid_t1", out_valid, 0);
        tick();
        chk("f1_valid_t2", out_valid, 0);
        tick();
        chk("f1_valid_t3", out_valid, 1);
        chk("f1_acc", out_acc, 16111);
        chk("f1_ovf", overflow, 0);
        tick();
        chk("f1_valid_after", out_valid, 0);

        for (int i = 0; i < 7; i++) begin
            beat(vecs[i].a, vecs[i].b, 1'b1);
            in_valid = 1'b0;
            tick(); tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_acc", i), out_acc, vecs[i].exp);
        end
        tick();

        // Back-to-back single-beat frames.
        beat(-128, -128, 1); beat(127, -128, 1);
        in_valid = 1'b0;
        tick();
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_acc0", out_acc, 16384);
        tick();
        chk("b2b_valid1", out_valid, 1);
        chk("b2b_acc1", out_acc, -16256);
        tick();
        chk("b2b_valid_end", out_valid, 0);

        // Consumer stall with an input beat offered throughout.
        out_ready = 1'b0;
        beat(1, 2, 1); beat(3, 3, 1); beat(4, 4, 1);
        a = 8'sd5; b = 8'sd5; last = 1'b1;
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_acc", out_acc, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
            chk($sformatf("stall%0d_acc", i), out_acc, 2);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("resume_acc0", out_acc, 9);
        tick();
        chk("resume_acc1", out_acc, 16);
        tick();
        chk("resume_acc2", out_acc, 25);
        chk("resume_valid2", out_valid, 1);
        tick();
        chk("resume_valid_end", out_valid, 0);

        // 16-bit accumulator overflow.
        beat(-128, -128, 0); beat(-128, -128, 1);
        in_valid = 1'b0;
        tick(); tick();
`ifdef MAC_SAT_EN
        sat16_exp = 32767; ovf16_exp = 1;
`else
        sat16_exp = -32768; ovf16_exp = 0;
`endif
        chk("w16_valid", out_valid16, 1);
        chk("w16_acc", out_acc16, sat16_exp);
        chk("w16_ovf", overflow16, ovf16_exp);
        chk("w24_acc", out_acc, 32768);
        chk("w24_ovf", overflow, 0);
        tick();

        // Abort an open frame; the beat offered with clear must be dropped.
        beat(10, 10, 0); beat(10, 10, 0); beat(10, 10, 0);
        clear = 1'b1; a = 8'sd9; b = 8'sd9; last = 1'b1;
        #1;
        chk("clear_in_ready", in_ready, 0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("clear%0d_valid", i), out_valid, 0);
        end
        beat(2, 3, 1);
        in_valid = 1'b0;
        tick(); tick();
        chk("post_clear_valid", out_valid, 1);
        chk("post_clear_acc", out_acc, 6);
        tick();

        // Reset with a pending result and a beat in flight.
        out_ready = 1'b0;
        beat(7, 7, 1); beat(1, 1, 0);
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_acc", out_acc, 49);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0; out_ready = 1'b1;
        beat(1, 1, 1);
        in_valid = 1'b0;
        tick(); tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_acc", out_acc, 1);
        tick();

        // Randomized handshakes against a frame-sum model.
        run = 0; flen = 0;
        for (int c = 0; c < 700; c++) begin
            if (c < 640) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                a         = 8'($urandom);
                b         = 8'($urandom);
                last      = ($urandom_range(0, 3) == 0) || (flen >= 31);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rand_unexpected_result", out_acc, -1);
                else                   chk("rand_result", out_acc, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                run += longint'(a) * longint'(b);
                flen++;
                if (last) begin
                    wrap24 = 24'(run);
                    exp_q.push_back(longint'(wrap24));
                    run = 0;
                    flen = 0;
                end
            end
            tick();
        end
        chk("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
